alarm_annunciator: RTL and testbench

Receive-side controller for the 8-zone intruder alarm bus. Consumes the priority-encoded `intruder_zone`/`valid` pair from the zone encoder. Decodes the code back to one lamp per zone, latches every zone reported, and drives a timed siren. Provides an operator acknowledge/clear handshake. Sits between the zone encoder and the front-panel lamps/siren driver.

---
 rtl/alarm_annunciator.sv | 157 +++++++++++++++
 tb/tb_alarm_annunciator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_annunciator.sv
// Receive-side alarm annunciator: decodes the encoded zone, latches lamps, times the siren.
// Optional lamp blinking while silenced is enabled by defining ANNUNCIATOR_BLINK_EN.
module alarm_annunciator #(
    parameter int SIREN_CYCLES = 1000,
    parameter int BLINK_HALF   = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] intruder_zone,
    input  logic       valid,
    input  logic       ack,
    output logic [1:8] zone_lamp,
    output logic [2:0] first_zone,
    output logic       siren,
    output logic       alarm_active,
    output logic [7:0] event_count
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ALARM    = 2'd1;
    localparam logic [1:0] SILENCED = 2'd2;

    localparam int CW = $clog2(SIREN_CYCLES);

    logic [1:0]    state_reg, state_next;
    logic [1:8]    latched_reg, latched_next;
    logic [2:0]    first_zone_reg, first_zone_next;
    logic [CW-1:0] siren_cnt_reg, siren_cnt_next;
    logic [7:0]    event_count_reg, event_count_next;
    logic [1:8]    zone_lamp_reg;
    logic          siren_reg;
    logic          alarm_active_reg;
    logic [1:8]    dec;
    logic          any_new;
    logic          lamp_on;

    genvar gi;
    generate
        for (gi = 1; gi <= 8; gi++) begin : g_dec
            assign dec[gi] = valid & (intruder_zone == 3'(gi - 1));
        end
    endgenerate

    assign any_new = |(dec & ~latched_reg);

    always_comb begin
        state_next       = state_reg;
        latched_next     = latched_reg;
        first_zone_next  = first_zone_reg;
        siren_cnt_next   = siren_cnt_reg;
        event_count_next = event_count_reg;
        case (state_reg)
            IDLE: begin
                if (valid) begin
                    first_zone_next = intruder_zone;
                    latched_next    = latched_reg | dec;
                    siren_cnt_next  = '0;
                    state_next      = ALARM;
                end
            end
            ALARM: begin
                latched_next = latched_reg | dec;
                // A new zone beats both ack and timeout: it restarts the siren.
                if (any_new) begin
                    siren_cnt_next = '0;
                end else if (ack || (siren_cnt_reg == CW'(SIREN_CYCLES - 1))) begin
                    state_next = SILENCED;
                end else begin
                    siren_cnt_next = siren_cnt_reg + CW'(1);
                end
            end
            SILENCED: begin
                if (any_new) begin
                    latched_next   = latched_reg | dec;
                    siren_cnt_next = '0;
                    state_next     = ALARM;
                end else if (ack && !valid) begin
                    // Clear is refused while any (already latched) zone still asserts.
                    latched_next    = '0;
                    first_zone_next = '0;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (any_new && (event_count_reg != 8'hFF)) begin
            event_count_next = event_count_reg + 8'd1;
        end
    end

`ifdef ANNUNCIATOR_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF + 1);

    logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
    logic          blink_phase_reg, blink_phase_next;

    always_comb begin
        blink_cnt_next   = blink_cnt_reg;
        blink_phase_next = blink_phase_reg;
        if (state_next == SILENCED && state_reg != SILENCED) begin
            blink_cnt_next   = '0;
            blink_phase_next = 1'b1;
        end else if (state_next == SILENCED) begin
            if (blink_cnt_reg == BW'(BLINK_HALF - 1)) begin
                blink_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + BW'(1);
            end
        end
        lamp_on = (state_next != SILENCED) | blink_phase_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
        end
    end
`else
    assign lamp_on = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            latched_reg      <= '0;
            first_zone_reg   <= '0;
            siren_cnt_reg    <= '0;
            event_count_reg  <= '0;
            zone_lamp_reg    <= '0;
            siren_reg        <= 1'b0;
            alarm_active_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            latched_reg      <= latched_next;
            first_zone_reg   <= first_zone_next;
            siren_cnt_reg    <= siren_cnt_next;
            event_count_reg  <= event_count_next;
            zone_lamp_reg    <= latched_next & {8{lamp_on}};
            siren_reg        <= (state_next == ALARM);
            alarm_active_reg <= (state_next != IDLE);
        end
    end

    assign zone_lamp    = zone_lamp_reg;
    assign first_zone   = first_zone_reg;
    assign siren        = siren_reg;
    assign alarm_active = alarm_active_reg;
    assign event_count  = event_count_reg;

endmodule

// File: tb/tb_alarm_annunciator.sv
// Directed self-checking bench for alarm_annunciator (SIREN_CYCLES=8, BLINK_HALF=4).
module tb_alarm_annunciator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] intruder_zone = 3'd0;
    logic       valid = 1'b0;
    logic       ack = 1'b0;
    logic [1:8] zone_lamp;
    logic [2:0] first_zone;
    logic       siren;
    logic       alarm_active;
    logic [7:0] event_count;

    int tests_run = 0;
    int tests_failed = 0;
    int hi;

    alarm_annunciator #(.SIREN_CYCLES(8), .BLINK_HALF(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .intruder_zone(intruder_zone),
        .valid(valid),
        .ack(ack),
        .zone_lamp(zone_lamp),
        .first_zone(first_zone),
        .siren(siren),
        .alarm_active(alarm_active),
        .event_count(event_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count siren-high cycles from the current (already high) cycle until it drops.
    task automatic measure_siren(output int n);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (siren) n++;
            else break;
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_siren", siren, 0);
        check("rst_lamp", zone_lamp, 0);
        check("rst_first", first_zone, 0);
        check("rst_count", event_count, 0);
        check("rst_active", alarm_active, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First event: code 4 -> zone 5
        tick();
        valid = 1'b1; intruder_zone = 3'd4;
        tick();
        valid = 1'b0;
        check("entry_siren", siren, 1);
        check("entry_lamp", zone_lamp, 8'b0000_1000);
        check("entry_first", first_zone, 4);
        check("entry_count", event_count, 1);
        check("entry_active", alarm_active, 1);

        measure_siren(hi);
        check("siren_len", hi, 8);
        check("sil_active", alarm_active, 1);
        check("sil_lamp0", zone_lamp, 8'b0000_1000);

        for (int k = 1; k <= 8; k++) begin
            tick();
`ifdef ANNUNCIATOR_BLINK_EN
            check("blink_lamp", zone_lamp, (((k / 4) % 2) == 0) ? 8'b0000_1000 : 8'b0000_0000);
`else
            check("steady_lamp", zone_lamp, 8'b0000_1000);
`endif
        end

        // Clear to IDLE
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("clr_lamp", zone_lamp, 0);
        check("clr_first", first_zone, 0);
        check("clr_active", alarm_active, 0);
        check("clr_count", event_count, 1);

        // Multiple zones in ALARM
        valid = 1'b1; intruder_zone = 3'd2;
        tick();
        intruder_zone = 3'd0;
        tick();
        intruder_zone = 3'd7;
        tick();
        valid = 1'b0;
        check("multi_lamp", zone_lamp, 8'b1010_0001);
        check("multi_first", first_zone, 2);
        check("multi_count", event_count, 4);
        tick(); tick(); tick();
        check("mid_siren", siren, 1);
        valid = 1'b1; intruder_zone = 3'd5;
        tick();
        valid = 1'b0;
        check("restart_lamp", zone_lamp, 8'b1010_0101);
        check("restart_count", event_count, 5);
        measure_siren(hi);
        check("restart_len", hi, 8);

        // SILENCED: ack together with a new zone -> back to ALARM
        ack = 1'b1; valid = 1'b1; intruder_zone = 3'd3;
        tick();
        valid = 1'b0;
        check("realarm_siren", siren, 1);
        check("realarm_lamp", zone_lamp, 8'b1011_0101);
        check("realarm_count", event_count, 6);
        tick();
        check("ack_silence", siren, 0);
        check("ack_sil_active", alarm_active, 1);
        valid = 1'b1; intruder_zone = 3'd0;
        tick();
        valid = 1'b0;
        check("refuse_active", alarm_active, 1);
        check("refuse_siren", siren, 0);
        check("refuse_lamp", zone_lamp, 8'b1011_0101);
        check("refuse_first", first_zone, 2);
        tick();
        check("clr2_lamp", zone_lamp, 0);
        check("clr2_active", alarm_active, 0);
        check("clr2_count", event_count, 6);
        tick();
        ack = 1'b0;
        check("idle_ack_active", alarm_active, 0);

        // Asynchronous reset mid-ALARM
        valid = 1'b1; intruder_zone = 3'd1;
        tick();
        valid = 1'b0;
        check("pre_rst_count", event_count, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_siren", siren, 0);
        check("arst_lamp", zone_lamp, 0);
        check("arst_count", event_count, 0);
        check("arst_active", alarm_active, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: 38 rounds of 8 new zones each
        for (int r = 0; r < 38; r++) begin
            for (int z = 0; z < 8; z++) begin
                valid = 1'b1; intruder_zone = 3'(z);
                tick();
            end
            valid = 1'b0; ack = 1'b1;
            tick();
            tick();
            ack = 1'b0;
            if (r == 0) check("sat_round1", event_count, 8);
            if (r == 30) check("sat_round31", event_count, 248);
        end
        check("sat_count", event_count, 255);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
